// File: rtl/ff_stimulus_driver.sv
// Stimulus generator and response checker for one flip-flop under test:
// drives LFSR data with periodic reset injection and scores Q against a one-cycle prediction.
module ff_stimulus_driver #(
  parameter int         NUM_VECTORS    = 64,
  parameter int         RESET_CYCLES   = 2,
  parameter int         RESET_INTERVAL = 16,
  parameter logic [7:0] LFSR_SEED      = 8'hA5,
  parameter int         ERR_CNT_WIDTH  = 8
) (
  input  logic                     CK,
  input  logic                     R,
  input  logic                     start,
  input  logic                     use_seed,
  input  logic [7:0]               seed_i,
  output logic                     dut_D,
  output logic                     dut_R,
  input  logic                     dut_Q,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic                     first_err_vld,
  output logic [15:0]              first_err_idx
);

  localparam logic [31:0] RC_LAST   = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] NV_LAST   = 32'(NUM_VECTORS - 1);
  localparam bit          INJ_EN    = (RESET_INTERVAL > 0);
  localparam logic [31:0] INJ_LAST  = INJ_EN ? 32'(RESET_INTERVAL - 1) : 32'd0;
  localparam logic [15:0] IDX_INIT  = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_RST,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[4], s[7:1]};
  endfunction

  // An all-zero state would lock the LFSR.
  function automatic logic [7:0] seed_fix(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + ERR_CNT_WIDTH'(1);
  endfunction

  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [31:0] inj_cnt, inj_nxt;
  logic [7:0]  lfsr, lfsr_nxt;
  logic        r_nxt, d_nxt, vld_nxt, fin_nxt, accept, inj_now;
  logic [15:0] idx_nxt;

  logic        vld_p1, fin_p1;
  logic [15:0] idx_p1;
  logic        vld_p2, exp_p2;
  logic [15:0] idx_p2;
  logic        mismatch_p2;

  assign inj_now = INJ_EN && (inj_cnt == INJ_LAST);

  // Stage p0: sequencing and next drive values
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    inj_nxt   = inj_cnt;
    lfsr_nxt  = lfsr;
    r_nxt     = 1'b1;
    d_nxt     = 1'b0;
    vld_nxt   = 1'b0;
    idx_nxt   = IDX_INIT;
    fin_nxt   = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: accept = start;
      S_INIT_RST: begin
        if (cnt == RC_LAST) begin
          vld_nxt   = 1'b1;
          state_nxt = S_RUN;
          cnt_nxt   = '0;
          inj_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      S_RUN: begin
        vld_nxt = 1'b1;
        idx_nxt = cnt[15:0];
        if (inj_now) begin
          inj_nxt = '0;
        end else begin
          r_nxt    = 1'b0;
          d_nxt    = lfsr[0];
          lfsr_nxt = lfsr_step(lfsr);
          inj_nxt  = inj_cnt + 32'd1;
        end
        if (cnt == NV_LAST) state_nxt = S_DRAIN;
        else                cnt_nxt   = cnt + 32'd1;
      end
      S_DRAIN: begin
        fin_nxt   = 1'b1;
        state_nxt = S_DONE;
      end
      // Wait for the final check to land before a restart can clear results.
      S_DONE:  accept = start && done;
      default: state_nxt = S_IDLE;
    endcase
    if (accept) begin
      state_nxt = S_INIT_RST;
      cnt_nxt   = '0;
      lfsr_nxt  = seed_fix(use_seed ? seed_i : LFSR_SEED);
    end
  end

  assign mismatch_p2 = vld_p2 && (dut_Q !== exp_p2);
  assign pass        = done && (err_count == '0);

  always_ff @(posedge CK) begin
    if (R) begin
      state         <= S_IDLE;
      cnt           <= '0;
      inj_cnt       <= '0;
      lfsr          <= seed_fix(LFSR_SEED);
      dut_R         <= 1'b1;
      dut_D         <= 1'b0;
      vld_p1        <= 1'b0;
      fin_p1        <= 1'b0;
      vld_p2        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_count     <= '0;
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      inj_cnt <= inj_nxt;
      lfsr    <= lfsr_nxt;
      // Stage p1: drive registers toward the FF under test
      dut_R   <= r_nxt;
      dut_D   <= d_nxt;
      vld_p1  <= vld_nxt;
      fin_p1  <= fin_nxt;
      // Stage p2: prediction captured alongside the DUT sampling edge
      vld_p2  <= vld_p1;
      if (accept) begin
        busy          <= 1'b1;
        done          <= 1'b0;
        err_count     <= '0;
        first_err_vld <= 1'b0;
        first_err_idx <= '0;
      end else begin
        if (fin_p1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        if (mismatch_p2) begin
          err_count <= sat_inc(err_count);
          if (!first_err_vld) begin
            first_err_vld <= 1'b1;
            first_err_idx <= idx_p2;
          end
        end
      end
    end
  end

  always_ff @(posedge CK) begin
    idx_p1 <= idx_nxt;
    exp_p2 <= dut_R ? 1'b0 : dut_D;
    idx_p2 <= idx_p1;
  end

endmodule

// File: tb/tb_ff_stimulus_driver.sv
// Bench for ff_stimulus_driver: three configurations, behavioural FF models,
// table-driven runs, directed reset abort and randomized seeds/fault modes.
module tb_ff_stimulus_driver;

  localparam int RC = 2;

  logic       CK = 1'b0;
  logic       R  = 1'b1;
  logic [2:0] start = '0, use_seed = '0, q = '0;
  logic [2:0] dD, dR, busy, done, pass, fev;
  logic [7:0] seed_a [3];
  logic [15:0] fei0, fei1, fei2;
  logic [7:0] err0, err1;
  logic [2:0] err2;
  int qmode [3];
  int checks = 0;
  int failures = 0;

  always #5 CK = ~CK;

  ff_stimulus_driver #(.NUM_VECTORS(8), .RESET_CYCLES(RC), .RESET_INTERVAL(0),
    .LFSR_SEED(8'hA5), .ERR_CNT_WIDTH(8)) u0 (
    .CK(CK), .R(R), .start(start[0]), .use_seed(use_seed[0]), .seed_i(seed_a[0]),
    .dut_D(dD[0]), .dut_R(dR[0]), .dut_Q(q[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .err_count(err0), .first_err_vld(fev[0]), .first_err_idx(fei0));

  ff_stimulus_driver #(.NUM_VECTORS(8), .RESET_CYCLES(RC), .RESET_INTERVAL(4),
    .LFSR_SEED(8'hA5), .ERR_CNT_WIDTH(8)) u1 (
    .CK(CK), .R(R), .start(start[1]), .use_seed(use_seed[1]), .seed_i(seed_a[1]),
    .dut_D(dD[1]), .dut_R(dR[1]), .dut_Q(q[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .err_count(err1), .first_err_vld(fev[1]), .first_err_idx(fei1));

  ff_stimulus_driver #(.NUM_VECTORS(64), .RESET_CYCLES(RC), .RESET_INTERVAL(0),
    .LFSR_SEED(8'hA5), .ERR_CNT_WIDTH(3)) u2 (
    .CK(CK), .R(R), .start(start[2]), .use_seed(use_seed[2]), .seed_i(seed_a[2]),
    .dut_D(dD[2]), .dut_R(dR[2]), .dut_Q(q[2]), .busy(busy[2]), .done(done[2]),
    .pass(pass[2]), .err_count(err2), .first_err_vld(fev[2]), .first_err_idx(fei2));

  // FF under test models: 0 ideal, 1 stuck at 0, 2 inverting
  always @(posedge CK) begin
    for (int k = 0; k < 3; k++) begin
      case (qmode[k])
        0:       q[k] <= dR[k] ? 1'b0 : dD[k];
        1:       q[k] <= 1'b0;
        default: q[k] <= ~(dR[k] ? 1'b0 : dD[k]);
      endcase
    end
  end

  function automatic int nv_of(input int k);  return (k == 2) ? 64 : 8; endfunction
  function automatic int ri_of(input int k);  return (k == 1) ? 4 : 0;  endfunction
  function automatic int max_of(input int k); return (k == 2) ? 7 : 255; endfunction

  function automatic int get_err(input int k);
    case (k)
      0:       return int'(err0);
      1:       return int'(err1);
      default: return int'(err2);
    endcase
  endfunction

  function automatic int get_fei(input int k);
    case (k)
      0:       return int'(fei0);
      1:       return int'(fei1);
      default: return int'(fei2);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // One full run on instance k, every driven cycle compared against a reference built from the rules.
  task automatic run_check(input int k, input bit us, input logic [7:0] sd, input int qm,
                           input bit ign, output int o_err, output int o_fei, output bit o_pass);
    int nv, ri, e, fi, last;
    bit vr[$];
    bit vd[$];
    logic [7:0] s;
    bit er, ed, ev, qv;
    nv = nv_of(k);
    ri = ri_of(k);
    s  = us ? sd : 8'hA5;
    if (s == 8'h00) s = 8'h01;
    for (int i = 0; i < nv; i++) begin
      if (ri > 0 && (i % ri) == ri - 1) begin
        vr.push_back(1'b1); vd.push_back(1'b0);
      end else begin
        vr.push_back(1'b0); vd.push_back(s[0]);
        s = {^(s & 8'h1D), s[7:1]};
      end
    end
    e  = 0;
    fi = -1;
    if (qm == 2) begin e++; fi = 16'hFFFF; end
    for (int i = 0; i < nv; i++) begin
      ev = vr[i] ? 1'b0 : vd[i];
      qv = (qm == 0) ? ev : (qm == 1) ? 1'b0 : ~ev;
      if (qv != ev) begin
        e++;
        if (fi < 0) fi = i;
      end
    end
    if (e > max_of(k)) e = max_of(k);

    @(negedge CK);
    qmode[k] = qm; use_seed[k] = us; seed_a[k] = sd; start[k] = 1'b1;
    @(posedge CK);
    #1 start[k] = 1'b0;
    last = RC + nv + 2;
    for (int c = 0; c <= last; c++) begin
      @(negedge CK);
      if (c >= RC + 1 && c <= RC + nv) begin
        er = vr[c - RC - 1]; ed = vd[c - RC - 1];
      end else begin
        er = 1'b1; ed = 1'b0;
      end
      chk($sformatf("k%0d_c%0d_dut_R", k, c), 32'(dR[k]), 32'(er));
      chk($sformatf("k%0d_c%0d_dut_D", k, c), 32'(dD[k]), 32'(ed));
      chk($sformatf("k%0d_c%0d_busy", k, c), 32'(busy[k]), 32'(c < last));
      chk($sformatf("k%0d_c%0d_done", k, c), 32'(done[k]), 32'(c >= last));
      start[k] = (ign && c == RC + 3) ? 1'b1 : 1'b0;
    end
    chk($sformatf("k%0d_err_count", k), 32'(get_err(k)), 32'(e));
    chk($sformatf("k%0d_first_err_vld", k), 32'(fev[k]), 32'(e > 0));
    chk($sformatf("k%0d_first_err_idx", k), 32'(get_fei(k)), 32'((fi < 0) ? 0 : fi));
    chk($sformatf("k%0d_pass", k), 32'(pass[k]), 32'(e == 0));
    o_err  = get_err(k);
    o_fei  = get_fei(k);
    o_pass = pass[k];
  endtask

  typedef struct {
    int         k;
    bit         us;
    logic [7:0] sd;
    int         qm;
    bit         ign;
    int         err;
    int         fei;
    bit         ps;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int oe, of;
    bit op;
    for (int k = 0; k < 3; k++) begin qmode[k] = 0; seed_a[k] = 8'h00; end
    // Hand-derived: seed A5 gives D stream 1,0,1,0,0,1,0,1
    tbl[0] = '{k:0, us:0, sd:8'h00, qm:0, ign:0, err:0, fei:0,      ps:1};
    tbl[1] = '{k:0, us:0, sd:8'h00, qm:1, ign:0, err:4, fei:0,      ps:0};
    tbl[2] = '{k:1, us:0, sd:8'h00, qm:0, ign:0, err:0, fei:0,      ps:1};
    tbl[3] = '{k:2, us:0, sd:8'h00, qm:2, ign:0, err:7, fei:16'hFFFF, ps:0};
    tbl[4] = '{k:0, us:1, sd:8'h00, qm:0, ign:1, err:0, fei:0,      ps:1};

    repeat (3) @(posedge CK);
    #1 R = 1'b0;
    @(negedge CK);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_k%0d_dut_R", k), 32'(dR[k]), 32'd1);
      chk($sformatf("rst_k%0d_dut_D", k), 32'(dD[k]), 32'd0);
      chk($sformatf("rst_k%0d_busy", k), 32'(busy[k]), 32'd0);
      chk($sformatf("rst_k%0d_done", k), 32'(done[k]), 32'd0);
      chk($sformatf("rst_k%0d_err", k), 32'(get_err(k)), 32'd0);
      chk($sformatf("rst_k%0d_fev", k), 32'(fev[k]), 32'd0);
    end

    for (int t = 0; t < 5; t++) begin
      run_check(tbl[t].k, tbl[t].us, tbl[t].sd, tbl[t].qm, tbl[t].ign, oe, of, op);
      chk($sformatf("tbl%0d_err", t), 32'(oe), 32'(tbl[t].err));
      chk($sformatf("tbl%0d_fei", t), 32'(of), 32'(tbl[t].fei));
      chk($sformatf("tbl%0d_pass", t), 32'(op), 32'(tbl[t].ps));
    end

    // Abort mid-run with a stuck FF: errors already counted must vanish.
    @(negedge CK);
    qmode[1] = 1; use_seed[1] = 1'b0; start[1] = 1'b1;
    @(posedge CK);
    #1 start[1] = 1'b0;
    for (int c = 0; c <= RC + 5; c++) @(negedge CK);
    chk("abort_err_before", 32'(err1), 32'd2);
    chk("abort_busy_before", 32'(busy[1]), 32'd1);
    R = 1'b1;
    @(posedge CK);
    #1 R = 1'b0;
    @(negedge CK);
    chk("abort_dut_R", 32'(dR[1]), 32'd1);
    chk("abort_dut_D", 32'(dD[1]), 32'd0);
    chk("abort_busy", 32'(busy[1]), 32'd0);
    chk("abort_done", 32'(done[1]), 32'd0);
    chk("abort_err", 32'(err1), 32'd0);
    chk("abort_fev", 32'(fev[1]), 32'd0);
    repeat (3) @(negedge CK);
    chk("abort_idle_dut_R", 32'(dR[1]), 32'd1);
    chk("abort_idle_busy", 32'(busy[1]), 32'd0);
    run_check(1, 1'b0, 8'h00, 0, 1'b0, oe, of, op);
    chk("abort_rerun_pass", 32'(op), 32'd1);

    for (int t = 0; t < 10; t++) begin
      run_check(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 8'($urandom),
                int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), oe, of, op);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
